// File: rtl/spi_target_regif.sv
// SPI mode-0 target bridging framed SPI transactions onto a single-cycle register bus.
// Optional burst mode (auto-incrementing address) enabled by defining SPI_TARGET_AUTOINC_EN.
module spi_target_regif #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       SCLK,
    input  logic       CS_N,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MISO_OE,
    output logic [6:0] REG_ADDR,
    output logic [7:0] REG_WDATA,
    output logic       REG_WE,
    output logic       REG_RE,
    input  logic [7:0] REG_RDATA,
    output logic       BUSY
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_DONE} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]             rx_q, rx_d;
    logic [7:0]             tx_q, tx_d;
    logic                   rw_q, rw_d;
    logic                   load_q, load_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic [6:0]             addr_q, addr_d;
    logic [7:0]             wdata_q, wdata_d;
    logic                   we_q, we_d;
    logic                   re_q, re_d;
    logic                   busy_q, busy_d;

    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_rise, sclk_fall, cs_fall;
    logic [7:0] rx_byte;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign rx_byte   = {rx_q[6:0], mosi_s};

    // Synchronizers, frame sequencing and register-bus strobes
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS_N};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        load_d      = re_q;
        miso_d      = miso_q;
        miso_oe_d   = ~cs_s;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        re_d        = 1'b0;

        // Read data arrives the cycle after the strobe
        if (load_q) begin
            tx_d = REG_RDATA;
        end
`ifdef SPI_TARGET_AUTOINC_EN
        // Advance the burst address once the write strobe has been seen
        if (we_q) begin
            addr_d = addr_q + 7'd1;
        end
`endif

        unique case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d   = ST_ADDR;
                    bit_cnt_d = '0;
                end
            end
            ST_ADDR: begin
                miso_d = 1'b0;
                if (sclk_rise) begin
                    rx_d      = rx_byte;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(7)) begin
                        state_d = ST_DATA;
                        rw_d    = rx_byte[7];
                        addr_d  = rx_byte[6:0];
                        re_d    = rx_byte[7];
                    end
                end
            end
            ST_DATA: begin
                if (sclk_rise) begin
                    rx_d      = rx_byte;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q[2:0] == 3'd7) begin
                        if (!rw_q) begin
                            wdata_d = rx_byte;
                            we_d    = 1'b1;
                        end
`ifdef SPI_TARGET_AUTOINC_EN
                        else begin
                            addr_d = addr_q + 7'd1;
                            re_d   = 1'b1;
                        end
`else
                        state_d = ST_DONE;
`endif
                    end
                end
                if (sclk_fall) begin
                    if (rw_q) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end else begin
                        miso_d = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                miso_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Deselect terminates the frame from any state
        if (cs_s) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            rw_q        <= 1'b0;
            load_q      <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            load_q      <= load_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            re_q        <= re_d;
            busy_q      <= busy_d;
        end
    end

    assign MISO      = miso_q;
    assign MISO_OE   = miso_oe_q;
    assign REG_ADDR  = addr_q;
    assign REG_WDATA = wdata_q;
    assign REG_WE    = we_q;
    assign REG_RE    = re_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_spi_target_regif.sv
// Bench for spi_target_regif: directed frames plus randomized back-to-back traffic
// against a transaction-level model (register memory, expected strobe lists).
module tb_spi_target_regif;

    logic       CLOCK_50 = 1'b0;
    logic       RESET;
    logic       SCLK;
    logic       CS_N;
    logic       MOSI;
    logic       MISO;
    logic       MISO_OE;
    logic [6:0] REG_ADDR;
    logic [7:0] REG_WDATA;
    logic       REG_WE;
    logic       REG_RE;
    logic [7:0] REG_RDATA = 8'h00;
    logic       BUSY;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem [128];
    logic [14:0] we_log [$];
    logic [6:0]  re_log [$];

`ifdef SPI_TARGET_AUTOINC_EN
    localparam int RE_PER_READ = 2;
`else
    localparam int RE_PER_READ = 1;
`endif

    spi_target_regif #(.SYNC_STAGES(2)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .SCLK     (SCLK),
        .CS_N     (CS_N),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .MISO_OE  (MISO_OE),
        .REG_ADDR (REG_ADDR),
        .REG_WDATA(REG_WDATA),
        .REG_WE   (REG_WE),
        .REG_RE   (REG_RE),
        .REG_RDATA(REG_RDATA),
        .BUSY     (BUSY)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Register file: read data valid the cycle after the strobe
    always @(posedge CLOCK_50) begin
        if (REG_RE) REG_RDATA <= mem[REG_ADDR];
    end

    always @(negedge CLOCK_50) begin
        if (REG_WE) we_log.push_back({REG_ADDR, REG_WDATA});
        if (REG_RE) re_log.push_back(REG_ADDR);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Initiator: bits left-aligned, MSB first; MISO sampled at each SCLK rise
    task automatic spi_frame(input logic [31:0] bits, input int nbits, input int half,
                             output logic [31:0] mo);
        mo   = '0;
        CS_N = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = bits[31-i];
            wait_cyc(half);
            SCLK      = 1'b1;
            mo[31-i]  = MISO;
            wait_cyc(half);
            SCLK = 1'b0;
        end
    endtask

    task automatic end_frame(input int half, input int gap);
        wait_cyc(half);
        CS_N = 1'b1;
        MOSI = 1'b0;
        wait_cyc(gap);
    endtask

    task automatic clear_logs();
        we_log.delete();
        re_log.delete();
    endtask

    function automatic logic [31:0] we_at(input int i);
        return (i < we_log.size()) ? 32'(we_log[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] re_at(input int i);
        return (i < re_log.size()) ? 32'(re_log[i]) : 32'hFFFF_FFFF;
    endfunction

    logic [31:0] mo;
    logic [6:0]  a;
    logic [7:0]  d;
    logic        rw;
    logic [14:0] exp_w [$];

    initial begin
        RESET = 1'b1;
        SCLK  = 1'b0;
        CS_N  = 1'b1;
        MOSI  = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);

        wait_cyc(4);
        chk("reset_outputs", 32'({MISO, MISO_OE, REG_ADDR, REG_WDATA, REG_WE, REG_RE, BUSY}), 32'h0);
        RESET = 1'b0;
        wait_cyc(4);

        // Single write
        clear_logs();
        spi_frame({8'h12, 8'hA5, 16'h0}, 16, 6, mo);
        chk("wr_busy_in_frame", 32'(BUSY), 32'h1);
        chk("wr_oe_in_frame", 32'(MISO_OE), 32'h1);
        end_frame(6, 8);
        chk("wr_count", 32'(we_log.size()), 32'd1);
        chk("wr_entry", we_at(0), 32'({7'h12, 8'hA5}));
        chk("wr_no_re", 32'(re_log.size()), 32'd0);
        chk("wr_busy_after", 32'(BUSY), 32'h0);
        chk("wr_oe_after", 32'(MISO_OE), 32'h0);
        chk("wr_miso_zero", mo, 32'h0);

        // Single read
        clear_logs();
        mem[7'h34] = 8'h3C;
        spi_frame({1'b1, 7'h34, 8'h00, 16'h0}, 16, 6, mo);
        end_frame(6, 8);
        chk("rd_addr_phase_miso", 32'(mo[31:24]), 32'h0);
        chk("rd_data", 32'(mo[23:16]), 32'h3C);
        chk("rd_re_count", 32'(re_log.size()), 32'(RE_PER_READ));
        chk("rd_re_addr", re_at(0), 32'h34);
        chk("rd_no_we", 32'(we_log.size()), 32'd0);

        // Abort after 12 bits, then a full write
        clear_logs();
        spi_frame({8'h05, 8'h5A, 16'h0}, 12, 6, mo);
        end_frame(6, 8);
        chk("abort_no_we", 32'(we_log.size()), 32'd0);
        spi_frame({8'h06, 8'h77, 16'h0}, 16, 6, mo);
        end_frame(6, 8);
        chk("post_abort_count", 32'(we_log.size()), 32'd1);
        chk("post_abort_entry", we_at(0), 32'({7'h06, 8'h77}));

        // Reset in the middle of a read
        clear_logs();
        spi_frame({1'b1, 7'h20, 8'h00, 16'h0}, 10, 6, mo);
        RESET = 1'b1;
        wait_cyc(3);
        chk("midreset_outputs", 32'({MISO, MISO_OE, REG_ADDR, REG_WDATA, REG_WE, REG_RE, BUSY}), 32'h0);
        SCLK = 1'b0;
        CS_N = 1'b1;
        MOSI = 1'b0;
        wait_cyc(4);
        RESET = 1'b0;
        wait_cyc(4);
        chk("midreset_idle", 32'({BUSY, MISO_OE}), 32'h0);
        clear_logs();
        spi_frame({8'h01, 8'hFF, 16'h0}, 16, 6, mo);
        end_frame(6, 8);
        chk("after_reset_count", 32'(we_log.size()), 32'd1);
        chk("after_reset_entry", we_at(0), 32'({7'h01, 8'hFF}));

        // Random back-to-back frames at minimum SCLK period and CS gap
        for (int n = 0; n < 10; n++) begin
            rw = 1'($urandom);
            a  = 7'($urandom);
            d  = 8'($urandom);
            clear_logs();
            spi_frame({rw, a, d, 16'h0}, 16, 5, mo);
            end_frame(5, 4);
            if (rw) begin
                chk("b2b_rd_data", 32'(mo[23:16]), 32'(mem[a]));
                chk("b2b_rd_strobe", {1'b0, re_at(0)[6:0], 8'(re_log.size()), 16'(we_log.size())},
                    {1'b0, a, 8'(RE_PER_READ), 16'd0});
            end else begin
                chk("b2b_wr_entry", we_at(0), 32'({a, d}));
                chk("b2b_wr_counts", {16'(we_log.size()), 16'(re_log.size())}, {16'd1, 16'd0});
            end
        end
        wait_cyc(8);

        // Burst write across the address wrap
        clear_logs();
        exp_w.delete();
        exp_w.push_back({7'h7E, 8'h11});
`ifdef SPI_TARGET_AUTOINC_EN
        exp_w.push_back({7'h7F, 8'h22});
        exp_w.push_back({7'h00, 8'h33});
`endif
        spi_frame({8'h7E, 8'h11, 8'h22, 8'h33}, 32, 6, mo);
        end_frame(6, 8);
        chk("burst_count", 32'(we_log.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size(); i++) begin
            chk("burst_entry", we_at(i), 32'(exp_w[i]));
        end
        chk("burst_no_re", 32'(re_log.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_target_regif.md
# spi_target_regif

SPI mode-0 target (responder) that terminates the 4-wire SPI link driven by the FPGA-side initiator and converts framed SPI transactions into single-cycle register-bus reads and writes. It sits on the chip side of the link, in the `CLOCK_50` domain, between the pad ring (SCLK, CS_N, MOSI, MISO) and the RFID core's control/status register file. All SPI inputs are oversampled and synchronized; there is no SCLK-clocked logic.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on SCLK, CS_N and MOSI (≥2).
- `CLOCK_50` in 1: system clock, all logic on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `SCLK` in 1: SPI clock from the initiator, asynchronous.
- `CS_N` in 1: chip select, active low, asynchronous.
- `MOSI` in 1: serial data from the initiator.
- `MISO` out 1: serial data to the initiator, 0 when not driving.
- `MISO_OE` out 1: pad output enable, 1 while CS_N is synchronized low.
- `REG_ADDR` out 7: register address.
- `REG_WDATA` out 8: write data.
- `REG_WE` out 1: one-cycle write strobe.
- `REG_RE` out 1: one-cycle read strobe.
- `REG_RDATA` in 8: read data, valid the cycle after `REG_RE`.
- `BUSY` out 1: high while a frame is in progress (state ≠ IDLE).

## Operation
- Frame: byte 0 = {RW, A[6:0]}, MSB first; RW=1 read, RW=0 write. Byte 1 = data, MSB first.
- Mode 0: MOSI sampled on synchronized SCLK rising edge; MISO updated on synchronized SCLK falling edge.
- States: IDLE → ADDR (CS_N falls) → DATA (8th rising edge) → DONE (16th rising edge) → IDLE (CS_N rises). CS_N rising from any state → IDLE.
- Bit counter 4 bits, cleared on CS_N falling edge.
- Read: on the 8th rising edge with RW=1, `REG_ADDR`←A and `REG_RE` pulses; the next cycle `REG_RDATA` loads the TX shift register. Bit 7 appears on MISO at the 8th falling edge and bits 6..0 follow on the 9th..15th falling edges.
- Write: on the 16th rising edge with RW=0, `REG_WDATA`←received byte and `REG_WE` pulses for one cycle.
- During the address byte and for any write, MISO = 0.
- Abort: if CS_N rises before the 16th rising edge, there is no `REG_WE`. A `REG_RE` already issued is not retracted.
- SCLK edges while CS_N is high are ignored.
- Reset values: MISO=0, MISO_OE=0, REG_ADDR=0, REG_WDATA=0, REG_WE=0, REG_RE=0, BUSY=0, state IDLE. Asserting RESET mid-frame returns to IDLE, and the block then waits for a fresh CS_N falling edge.

## Timing
- Input latency: SYNC_STAGES + 1 cycles from pin to edge-detect pulse.
- Required SCLK period ≥ 10 `CLOCK_50` cycles, with high and low phases each ≥ 5 cycles.
- The read path (sync, detect, RE, capture, shift-load) completes within 5 cycles, before the 8th falling edge is detected.
- `REG_WE` is asserted SYNC_STAGES+2 cycles after the 16th SCLK rising edge at the pin.
- CS_N high time between frames ≥ 4 cycles.

## Configuration
- `SPI_TARGET_AUTOINC_EN` defined: burst mode.
  - After each data byte, `REG_ADDR` increments, wrapping 7'h7F→7'h00, and the frame continues with another data byte.
  - Burst reads issue the next `REG_RE` on the rising edge that completes each data byte (bit counter modulo 8), prefetching the next byte.
  - Burst writes issue `REG_WE` after every 8 data bits.
- Not defined: after the 16th rising edge, further SCLK edges are ignored until CS_N rises, and MISO is held at 0.

## Test plan
- Write 0x12→0xA5 (frame 0x12,0xA5) → exactly one `REG_WE` pulse with REG_ADDR=0x12 and REG_WDATA=0xA5; BUSY falls after CS_N rises.
- Read 0x34 with REG_RDATA model 0x3C → one `REG_RE` with REG_ADDR=0x34; MISO bits sampled by the initiator = 0x3C; MISO=0 during the address byte.
- Abort: CS_N rises after 12 bits of a write to 0x05 → no `REG_WE`; the next full write to 0x06 with data 0x77 succeeds.
- RESET asserted at bit 10 of a read → all outputs return to reset values, and the next frame (write 0x01←0xFF) completes normally.
- Minimum SCLK (period 10 cycles), back-to-back frames with 4-cycle CS_N gap → read data intact, no missed strobes.
- With `SPI_TARGET_AUTOINC_EN`: write burst starting at 0x7E with data 0x11,0x22,0x33 → writes 0x7E=0x11, 0x7F=0x22, 0x00=0x33. Without the macro, the same stimulus → only 0x7E=0x11 is written.
